// File: rtl/axis_sa_serializer.sv
// Drains the systolic array's wide accumulator stream as narrow beats of P lanes.
// Each lane is arithmetically shifted right and then signed-saturated to WO bits.
module axis_sa_serializer #(
  parameter int R     = 4,
  parameter int P     = 2,
  parameter int WY    = 16,
  parameter int WO    = 8,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [R-1:0][WY-1:0]   s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [P-1:0][WO-1:0]   m_data
);

  localparam int N  = R / P;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WE = (WO > WY) ? WO : WY;

  localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);
  localparam logic signed [WE-1:0] MAX_O    = {{(WE - WO + 1){1'b0}}, {(WO - 1){1'b1}}};
  localparam logic signed [WE-1:0] MIN_O    = {{(WE - WO + 1){1'b1}}, {(WO - 1){1'b0}}};

  if (R % P != 0) begin : g_bad_ratio
    $error("axis_sa_serializer: R must be a multiple of P");
  end
  if (SHIFT < 0 || SHIFT >= WY) begin : g_bad_shift
    $error("axis_sa_serializer: SHIFT must lie in 0..WY-1");
  end
  if (WO < 2) begin : g_bad_wo
    $error("axis_sa_serializer: WO must be at least 2");
  end

  // Sign-preserving shift (floors toward -inf), then clamp into the WO-bit range.
  function automatic logic [WO-1:0] sat_lane(input logic [WY-1:0] x);
    logic signed [WY-1:0] sh;
    logic signed [WE-1:0] ext;
    logic [WO-1:0]        res;
    sh  = $signed(x) >>> SHIFT;
    ext = WE'(sh);
    if (WO >= WY) begin
      res = ext[WO-1:0];
    end else if (ext > MAX_O) begin
      res = MAX_O[WO-1:0];
    end else if (ext < MIN_O) begin
      res = MIN_O[WO-1:0];
    end else begin
      res = ext[WO-1:0];
    end
    return res;
  endfunction

  logic [R-1:0][WY-1:0] buf_data_q, buf_data_d;
  logic                 buf_last_q, buf_last_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [N-1:0][P-1:0][WY-1:0] buf_grp;
  logic                        at_last_sub;
  logic                        m_fire;
  logic                        s_fire;

  assign buf_grp = buf_data_q;

  always_comb begin
    at_last_sub = (idx_q == LAST_IDX);
    s_ready     = !buf_valid_q || (m_ready && at_last_sub);
    m_valid     = buf_valid_q;
    m_last      = buf_last_q && at_last_sub;
    m_fire      = buf_valid_q && m_ready;
    s_fire      = s_valid && s_ready;
    for (int p = 0; p < P; p++) begin
      m_data[p] = sat_lane(buf_grp[idx_q][p]);
    end
  end

  // A load on the final sub-beat overrides the clear so the stream has no bubble.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    if (m_fire) begin
      if (at_last_sub) begin
        idx_d       = '0;
        buf_valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    if (s_fire) begin
      buf_data_d  = s_data;
      buf_last_d  = s_last;
      buf_valid_d = 1'b1;
      idx_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_axis_sa_serializer.sv
// Directed bench: a SHIFT=0 serializer for the main sequence plus a SHIFT=4 copy
// for the shifted-saturation vector; inputs change and outputs are sampled 1ns after posedge.
module tb_axis_sa_serializer;

  logic clk;
  logic rstn;

  logic             s_valid, s_ready, s_last;
  logic [3:0][15:0] s_data;
  logic             m_valid, m_ready, m_last;
  logic [1:0][7:0]  m_data;

  logic             sh_s_valid, sh_s_ready, sh_s_last;
  logic [3:0][15:0] sh_s_data;
  logic             sh_m_valid, sh_m_ready, sh_m_last;
  logic [1:0][7:0]  sh_m_data;

  int checks   = 0;
  int failures = 0;

  axis_sa_serializer #(.R(4), .P(2), .WY(16), .WO(8), .SHIFT(0)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_data  (m_data)
  );

  axis_sa_serializer #(.R(4), .P(2), .WY(16), .WO(8), .SHIFT(4)) dut_sh (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (sh_s_valid),
    .s_ready (sh_s_ready),
    .s_last  (sh_s_last),
    .s_data  (sh_s_data),
    .m_valid (sh_m_valid),
    .m_ready (sh_m_ready),
    .m_last  (sh_m_last),
    .m_data  (sh_m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input int l0, input int l1);
    logic [7:0] a;
    logic [7:0] b;
    a = l0[7:0];
    b = l1[7:0];
    return {b, a};
  endfunction

  task automatic applyStimulus(input logic v, input logic last,
                               input int d0, input int d1, input int d2, input int d3,
                               input logic mr);
    s_valid = v;
    s_last  = last;
    s_data  = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    m_ready = mr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn       = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    sh_s_valid = 1'b0;
    sh_s_last  = 1'b0;
    sh_s_data  = '0;
    sh_m_ready = 1'b1;

    // Reset held for three cycles
    repeat (3) tick();
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_last",  32'(m_last),  32'd0);
    checkOutput("rst_m_data",  32'(m_data),  32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    rstn = 1'b1;
    tick();
    checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);

    // Basic split {1,2,3,4}
    applyStimulus(1'b1, 1'b0, 1, 2, 3, 4, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("split0_valid", 32'(m_valid), 32'd1);
    checkOutput("split0_data",  32'(m_data),  32'(pk(1, 2)));
    checkOutput("split0_last",  32'(m_last),  32'd0);
    checkOutput("split0_ready", 32'(s_ready), 32'd0);
    tick();
    checkOutput("split1_data",  32'(m_data),  32'(pk(3, 4)));
    checkOutput("split1_last",  32'(m_last),  32'd0);
    checkOutput("split1_ready", 32'(s_ready), 32'd1);
    tick();
    checkOutput("split_drained", 32'(m_valid), 32'd0);

    // Saturation on both instances
    applyStimulus(1'b1, 1'b0, 300, -300, 127, -128, 1'b1);
    sh_s_valid = 1'b1;
    sh_s_data  = {16'h0000, 16'h7FF0, 16'(-32), 16'h0123};
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    sh_s_valid = 1'b0;
    checkOutput("sat0_data",    32'(m_data),    32'(pk(127, -128)));
    checkOutput("sh_sat0_data", 32'(sh_m_data), 32'(pk(18, -2)));
    checkOutput("sh_sat0_valid", 32'(sh_m_valid), 32'd1);
    tick();
    checkOutput("sat1_data",    32'(m_data),    32'(pk(127, -128)));
    checkOutput("sh_sat1_data", 32'(sh_m_data), 32'(pk(127, 0)));
    tick();
    checkOutput("sat_drained",    32'(m_valid),    32'd0);
    checkOutput("sh_sat_drained", 32'(sh_m_valid), 32'd0);

    // Backpressure on the second sub-beat with a new beat waiting
    applyStimulus(1'b1, 1'b0, 1, 2, 3, 4, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("bp_sub0_data", 32'(m_data), 32'(pk(1, 2)));
    tick();
    applyStimulus(1'b1, 1'b0, 9, 10, 11, 12, 1'b0);
    #1;
    checkOutput("bp_ready_drop", 32'(s_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(m_valid), 32'd1);
      checkOutput("bp_hold_data",  32'(m_data),  32'(pk(3, 4)));
      checkOutput("bp_hold_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(s_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("bp_next0_data", 32'(m_data), 32'(pk(9, 10)));
    tick();
    checkOutput("bp_next1_data", 32'(m_data), 32'(pk(11, 12)));
    tick();
    checkOutput("bp_drained", 32'(m_valid), 32'd0);

    // Eight back-to-back beats, tile last on the eighth
    applyStimulus(1'b1, 1'b0, 0, 1, 2, 3, 1'b1);
    for (int c = 0; c < 16; c++) begin
      int b;
      int sub;
      int nb;
      tick();
      b   = c / 2;
      sub = c % 2;
      nb  = b + 1;
      if (nb < 8) applyStimulus(1'b1, (nb == 7), 4*nb, 4*nb+1, 4*nb+2, 4*nb+3, 1'b1);
      else        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
      checkOutput("stream_valid", 32'(m_valid), 32'd1);
      checkOutput("stream_data",  32'(m_data),  32'(pk(4*b + 2*sub, 4*b + 2*sub + 1)));
      checkOutput("stream_last",  32'(m_last),  32'(c == 15));
      checkOutput("stream_ready", 32'(s_ready), 32'(sub == 1));
    end
    tick();
    checkOutput("stream_drained", 32'(m_valid), 32'd0);

    // Reset after the first sub-beat discards the remainder
    applyStimulus(1'b1, 1'b0, 5, 6, 7, 8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("mid_sub0_data", 32'(m_data), 32'(pk(5, 6)));
    rstn = 1'b0;
    tick();
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_data",  32'(m_data),  32'd0);
    checkOutput("mid_rst_ready", 32'(s_ready), 32'd1);
    rstn = 1'b1;
    tick();
    checkOutput("mid_after_valid", 32'(m_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 20, 21, 22, 23, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("mid_new0_data", 32'(m_data), 32'(pk(20, 21)));
    checkOutput("mid_new0_last", 32'(m_last), 32'd0);
    tick();
    checkOutput("mid_new1_data", 32'(m_data), 32'(pk(22, 23)));
    checkOutput("mid_new1_last", 32'(m_last), 32'd1);
    tick();
    checkOutput("mid_drained", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
